// File: rtl/dct8_coeff_reorder_if.sv
// Bus bundle for dct8_coeff_reorder.
//   Capture side : coeff_in / valid_in / index_in (no backpressure)
//   Replay side  : data_out / valid_out / ready_in / index_out / last_out
//   Status       : dup_err, ovf_err (1-cycle pulses)
// Modports: slave = the reorder block, master = the producer/consumer around it.
interface dct8_coeff_reorder_if #(
  parameter int unsigned IN_W   = 18,
  parameter int unsigned DATA_W = 12
);
  logic [IN_W-1:0]   coeff_in;
  logic              valid_in;
  logic [2:0]        index_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              ready_in;
  logic [2:0]        index_out;
  logic              last_out;
  logic              dup_err;
  logic              ovf_err;

  modport slave (
    input  coeff_in, valid_in, index_in, ready_in,
    output data_out, valid_out, index_out, last_out, dup_err, ovf_err
  );

  modport master (
    output coeff_in, valid_in, index_in, ready_in,
    input  data_out, valid_out, index_out, last_out, dup_err, ovf_err
  );
endinterface

// File: rtl/dct8_coeff_reorder.sv
// dct8_coeff_reorder: captures an 8-coefficient block arriving in any index
// order into a ping-pong pair of banks, then replays each complete block in
// natural order 0..7 over a valid/ready handshake, narrowed to DATA_W.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - dct8_coeff_reorder_if.slave (capture stream, replay stream, error pulses)
// Configuration macro:
//   DCT8_REORDER_SAT_EN - defined: signed saturation to DATA_W; undefined: truncation.
module dct8_coeff_reorder #(
  parameter int unsigned IN_W   = 18,
  parameter int unsigned DATA_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  dct8_coeff_reorder_if.slave  bus
);
  localparam int unsigned DEPTH = 8;
  localparam int unsigned IDX_W = 3;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [DATA_W-1:0] mem [2][DEPTH];
  logic [DEPTH-1:0]  mask [2];
  logic [1:0]        full, full_nx;
  logic              fill_ptr;
  logic              dr_ptr, dr_nx;
  logic [0:0]        state, state_nx;
  logic [IDX_W-1:0]  rd_idx, rd_nx;
  logic              release_c;

  logic              wr_en, complete, dup, ovf;
  logic [DEPTH-1:0]  wr_mask;

  logic              valid_q, valid_nx;
  logic [DATA_W-1:0] data_q, data_nx;
  logic [IDX_W-1:0]  index_q, index_nx;
  logic              last_q, last_nx;
  logic              dup_q, ovf_q;

  // Narrow an incoming coefficient to the replay width.
  function automatic logic [DATA_W-1:0] narrow(input logic [IN_W-1:0] x);
`ifdef DCT8_REORDER_SAT_EN
    // In range when every bit above the result sign bit matches it.
    if (x[IN_W-1:DATA_W-1] == {(IN_W-DATA_W+1){x[IN_W-1]}})
      return x[DATA_W-1:0];
    else if (x[IN_W-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
`else
    return x[DATA_W-1:0];
`endif
  endfunction

`ifndef DCT8_REORDER_SAT_EN
  logic unused_coeff_hi;
  assign unused_coeff_hi = ^bus.coeff_in[IN_W-1:DATA_W];
`endif

  // Capture side: a full fill bank drops the sample, a repeated index overwrites.
  always_comb begin
    wr_en    = bus.valid_in & ~full[fill_ptr];
    ovf      = bus.valid_in &  full[fill_ptr];
    wr_mask  = mask[fill_ptr] | (DEPTH'(1) << bus.index_in);
    dup      = wr_en & mask[fill_ptr][bus.index_in];
    complete = wr_en & (wr_mask == {DEPTH{1'b1}});
  end

  // Bank full flags: the drain releases its bank, a completing write claims the fill bank.
  always_comb begin
    full_nx = full;
    if (release_c) full_nx[dr_ptr]   = 1'b0;
    if (complete)  full_nx[fill_ptr] = 1'b1;
  end

  // Coefficient storage (contents are qualified by mask/full, so no reset).
  always_ff @(posedge clk) begin
    if (wr_en) mem[fill_ptr][bus.index_in] <= narrow(bus.coeff_in);
  end

  // Fill-side bookkeeping and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask[0]  <= '0;
      mask[1]  <= '0;
      full     <= '0;
      fill_ptr <= 1'b0;
      dup_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      dup_q <= dup;
      ovf_q <= ovf;
      full  <= full_nx;
      if (wr_en) mask[fill_ptr] <= complete ? '0 : wr_mask;
      if (complete) fill_ptr <= ~fill_ptr;
    end
  end

  // Drain FSM next-state and next-output logic.
  always_comb begin
    state_nx  = state;
    rd_nx     = rd_idx;
    dr_nx     = dr_ptr;
    release_c = 1'b0;
    valid_nx  = valid_q;
    data_nx   = data_q;
    index_nx  = index_q;
    last_nx   = last_q;
    case (state)
      IDLE: begin
        valid_nx = 1'b0;
        last_nx  = 1'b0;
        if (full[dr_ptr]) begin
          state_nx = DRAIN;
          rd_nx    = '0;
          valid_nx = 1'b1;
          data_nx  = mem[dr_ptr][0];
          index_nx = '0;
        end
      end
      DRAIN: begin
        if (bus.ready_in) begin
          if (rd_idx == IDX_W'(DEPTH-1)) begin
            release_c = 1'b1;
            dr_nx     = ~dr_ptr;
            last_nx   = 1'b0;
            if (full[~dr_ptr]) begin
              // Other bank already waiting: continue with no bubble.
              rd_nx    = '0;
              data_nx  = mem[~dr_ptr][0];
              index_nx = '0;
            end else begin
              state_nx = IDLE;
              valid_nx = 1'b0;
            end
          end else begin
            rd_nx    = IDX_W'(rd_idx + IDX_W'(1));
            data_nx  = mem[dr_ptr][rd_nx];
            index_nx = rd_nx;
            last_nx  = (rd_nx == IDX_W'(DEPTH-1));
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Drain FSM state and registered replay outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_idx  <= '0;
      dr_ptr  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      rd_idx  <= rd_nx;
      dr_ptr  <= dr_nx;
      valid_q <= valid_nx;
      data_q  <= data_nx;
      index_q <= index_nx;
      last_q  <= last_nx;
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;
  assign bus.index_out = index_q;
  assign bus.last_out  = last_q;
  assign bus.dup_err   = dup_q;
  assign bus.ovf_err   = ovf_q;
endmodule

// File: tb/tb_dct8_coeff_reorder.sv
// Bench for dct8_coeff_reorder: directed scenarios plus randomized blocks,
// scored against a block-level reference model with an expected-beat queue.
module tb_dct8_coeff_reorder;
  localparam int unsigned IN_W   = 18;
  localparam int unsigned DATA_W = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dct8_coeff_reorder_if #(.IN_W(IN_W), .DATA_W(DATA_W)) bus();
  dct8_coeff_reorder #(.IN_W(IN_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [2:0]        idx;
    logic              last;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference narrowing in plain integer arithmetic.
  function automatic logic [DATA_W-1:0] narrow_ref(input int v);
    int lo, hi, r;
    lo = -(1 <<< (DATA_W-1));
    hi = (1 <<< (DATA_W-1)) - 1;
    r  = v;
`ifdef DCT8_REORDER_SAT_EN
    if (r > hi) r = hi;
    if (r < lo) r = lo;
`endif
    return DATA_W'(r);
  endfunction

  // Reference model: one open fill block, count of stored blocks (max 2).
  int  fill_val [8];
  bit  [7:0] fill_mask;
  int  nfull;
  int  drained;
  bit  exp_dup, exp_ovf;

  always @(negedge clk) begin
    bit new_dup, new_ovf, done;
    int ix;
    if (rst) begin
      fill_mask = '0;
      nfull     = 0;
      drained   = 0;
      exp_dup   = 1'b0;
      exp_ovf   = 1'b0;
      exp_q.delete();
    end else begin
      chk("dup_err", 32'(bus.dup_err), 32'(exp_dup));
      chk("ovf_err", 32'(bus.ovf_err), 32'(exp_ovf));
      new_dup = 1'b0;
      new_ovf = 1'b0;
      done    = 1'b0;
      if (bus.valid_in) begin
        if (nfull >= 2) begin
          new_ovf = 1'b1;
        end else begin
          ix = int'(bus.index_in);
          if (fill_mask[ix]) new_dup = 1'b1;
          fill_mask[ix] = 1'b1;
          fill_val[ix]  = int'($signed(bus.coeff_in));
          if (fill_mask == 8'hFF) begin
            for (int i = 0; i < 8; i++)
              exp_q.push_back('{data: narrow_ref(fill_val[i]), idx: 3'(i), last: (i == 7)});
            fill_mask = '0;
            done      = 1'b1;
          end
        end
      end
      // A bank freed on this edge is not yet available to the write above.
      if (bus.valid_out && bus.ready_in) begin
        drained++;
        if (drained == 8) begin
          drained = 0;
          if (nfull > 0) nfull--;
        end
      end
      if (done) nfull++;
      exp_dup = new_dup;
      exp_ovf = new_ovf;
    end
  end

  // Monitor: score accepted beats and hold-stability under backpressure.
  bit    hold_pend = 1'b0;
  beat_t hold_beat;

  always @(negedge clk) begin
    beat_t cur, e;
    cur = '{data: bus.data_out, idx: bus.index_out, last: bus.last_out};
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 32'(bus.valid_out), 32'd1);
        chk("hold_beat", 32'(cur), 32'(hold_beat));
      end
      hold_pend = bus.valid_out && !bus.ready_in;
      hold_beat = cur;
      if (bus.valid_out && bus.ready_in) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(cur), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 32'(cur), 32'(e));
        end
      end
    end
  end

  // Ready generator: 0 = driven by the stimulus, 1 = random, 2 = 1,0,0,1 pattern.
  int rdy_mode = 0;
  int rdy_cyc  = 0;
  always @(posedge clk) begin
    #2;
    rdy_cyc++;
    case (rdy_mode)
      1: bus.ready_in = 1'($urandom_range(0, 1));
      2: bus.ready_in = ((rdy_cyc % 4) == 0) || ((rdy_cyc % 4) == 3);
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int idx, input int v);
    bus.valid_in = 1'b1;
    bus.index_in = 3'(idx);
    bus.coeff_in = IN_W'(v);
    tick();
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.valid_out) && n < 400) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n >= 400), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int perm [8];
    int t, j;
    logic [DATA_W-1:0] sat0;
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    bus.index_in = '0;
    bus.coeff_in = '0;
    bus.ready_in = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_last",  32'(bus.last_out),  32'd0);
    chk("rst_dup",   32'(bus.dup_err),   32'd0);
    chk("rst_ovf",   32'(bus.ovf_err),   32'd0);
    chk("rst_data",  32'(bus.data_out),  32'd0);
    chk("rst_index", 32'(bus.index_out), 32'd0);
    rst = 1'b0;
    tick();

    // In-order fill with latency check.
    bus.ready_in = 1'b1;
    for (int i = 0; i < 8; i++) put(i, 10 + i);
    chk("lat_before", 32'(bus.valid_out), 32'd0);
    tick();
    chk("lat_valid", 32'(bus.valid_out), 32'd1);
    chk("lat_data",  32'(bus.data_out),  32'd10);
    wait_drain();

    // Scrambled order.
    begin
      int ord [8] = '{7, 3, 0, 5, 1, 6, 2, 4};
      for (int i = 0; i < 8; i++) put(ord[i], 100 * ord[i]);
    end
    wait_drain();

    // Backpressure pattern.
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) put(i, int'($urandom_range(0, 4000)) - 2000);
    wait_drain();
    rdy_mode = 0;
    tick();

    // Ping-pong: three blocks with ready low; third block overflows.
    bus.ready_in = 1'b0;
    for (int b = 1; b <= 3; b++)
      for (int i = 0; i < 8; i++) put(i, 1000 * b + i);
    tick();
    chk("pp_valid", 32'(bus.valid_out), 32'd1);
    chk("pp_data",  32'(bus.data_out),  32'd1000);
    bus.ready_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("pp_no_bubble", 32'(bus.valid_out), 32'd1);
      tick();
    end
    chk("pp_done", 32'(bus.valid_out), 32'd0);
    wait_drain();

    // Duplicate index.
    put(2, 5);
    put(0, 1);
    put(2, 9);
    for (int i = 1; i < 8; i++) if (i != 2) put(i, 20 + i);
    wait_drain();

    // Narrowing at the range edges.
    bus.ready_in = 1'b0;
    put(0, 4095);
    put(1, -4096);
    put(2, 2047);
    put(3, -2048);
    put(4, 131071);
    put(5, -131072);
    put(6, 2048);
    put(7, -2049);
    tick();
`ifdef DCT8_REORDER_SAT_EN
    sat0 = 12'd2047;
`else
    sat0 = 12'hFFF;
`endif
    chk("narrow_4095", 32'(bus.data_out), 32'(sat0));
    bus.ready_in = 1'b1;
    wait_drain();

    // Reset mid-block with one stored block pending.
    bus.ready_in = 1'b0;
    for (int i = 0; i < 8; i++) put(i, 300 + i);
    for (int i = 0; i < 4; i++) put(i, 400 + i);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", 32'(bus.valid_out), 32'd0);
    bus.ready_in = 1'b1;
    repeat (5) tick();
    chk("no_stale", 32'(bus.valid_out), 32'd0);
    for (int i = 0; i < 8; i++) put(i, 500 + i);
    wait_drain();

    // Randomized blocks with random ready and gaps.
    rdy_mode = 1;
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < 8; i++) perm[i] = i;
      for (int i = 7; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      if ($urandom_range(0, 9) == 0) put(perm[0], int'($urandom_range(0, 262143)) - 131072);
      for (int i = 0; i < 8; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        if ($urandom_range(0, 3) == 0)
          put(perm[i], int'($urandom_range(0, 262143)) - 131072);
        else
          put(perm[i], int'($urandom_range(0, 6000)) - 3000);
      end
    end
    rdy_mode = 0;
    tick();
    bus.ready_in = 1'b1;
    wait_drain();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
